// File: rtl/vlsu_sequencer_if.sv
// Request, DMEM and VRF-write bundle of the vector load/store sequencer.
// The mask signals exist only when VLSU_MASK_EN is defined.
interface vlsu_sequencer_if #(
   parameter int XLEN            = 32,
   parameter int DATA_ADDR_WIDTH = 10,
   parameter int VLEN            = 128,
   parameter int ELEN            = 32
);
   localparam int VL_W = $clog2(VLEN / 8) + 1;

   logic                       req_valid;
   logic                       req_ready;
   logic                       req_store;
   logic [XLEN-1:0]            req_base;
   logic [XLEN-1:0]            req_stride;
   logic [1:0]                 req_sew;
   logic [VL_W-1:0]            req_vl;
   logic [4:0]                 req_vd;
   logic [VLEN-1:0]            req_data;
`ifdef VLSU_MASK_EN
   logic                       req_vm;
   logic [VLEN/8-1:0]          req_mask;
`endif
   logic [DATA_ADDR_WIDTH-1:0] mem_addr;
   logic                       mem_re;
   logic                       mem_we;
   logic [1:0]                 mem_size;
   logic [ELEN-1:0]            mem_wdata;
   logic [ELEN-1:0]            mem_rdata;
   logic                       vrf_we;
   logic [4:0]                 vrf_waddr;
   logic [VLEN-1:0]            vrf_wdata;
   logic                       busy;
   logic                       done;
   logic                       err;

   // Sequencer side
   modport slave (
`ifdef VLSU_MASK_EN
      input  req_vm,
      input  req_mask,
`endif
      input  req_valid,
      input  req_store,
      input  req_base,
      input  req_stride,
      input  req_sew,
      input  req_vl,
      input  req_vd,
      input  req_data,
      input  mem_rdata,
      output req_ready,
      output mem_addr,
      output mem_re,
      output mem_we,
      output mem_size,
      output mem_wdata,
      output vrf_we,
      output vrf_waddr,
      output vrf_wdata,
      output busy,
      output done,
      output err
   );

   // Issue / memory / VRF side
   modport master (
`ifdef VLSU_MASK_EN
      output req_vm,
      output req_mask,
`endif
      output req_valid,
      output req_store,
      output req_base,
      output req_stride,
      output req_sew,
      output req_vl,
      output req_vd,
      output req_data,
      output mem_rdata,
      input  req_ready,
      input  mem_addr,
      input  mem_re,
      input  mem_we,
      input  mem_size,
      input  mem_wdata,
      input  vrf_we,
      input  vrf_waddr,
      input  vrf_wdata,
      input  busy,
      input  done,
      input  err
   );
endinterface

// File: rtl/vlsu_sequencer.sv
// Vector unit-stride/strided load/store sequencer: one element per cycle on the scalar DMEM port,
// single VRF write for loads. Optional per-element masking under VLSU_MASK_EN.
module vlsu_sequencer #(
   parameter int XLEN            = 32,
   parameter int DATA_ADDR_WIDTH = 10,
   parameter int VLEN            = 128,
   parameter int ELEN            = 32
) (
   input logic              clk,
   input logic              rst,
   vlsu_sequencer_if.slave  bus
);
   localparam int VL_W   = $clog2(VLEN / 8) + 1;
   localparam int OFF_W  = $clog2(VLEN);
   localparam int WIDE_W = OFF_W + VL_W;
   localparam int MAX_EL = VLEN / 8;
   localparam int IDX_W  = $clog2(MAX_EL);
   localparam logic [VL_W-1:0] VL_ZERO = VL_W'(0);
   localparam logic [VL_W-1:0] VL_ONE  = VL_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WB     = 2'd2
   } state_t;

   // Bit offset of element idx inside a VLEN word for the given SEW.
   function automatic logic [OFF_W-1:0] elem_off(input logic [1:0] sew, input logic [VL_W-1:0] idx);
      logic [WIDE_W-1:0] wide;
      wide = WIDE_W'(idx) << ({1'b0, sew} + 3'd3);
      return wide[OFF_W-1:0];
   endfunction

   function automatic logic [ELEN-1:0] elem_get(input logic [VLEN-1:0] vec, input logic [1:0] sew,
                                               input logic [VL_W-1:0] idx);
      logic [OFF_W-1:0] off;
      logic [ELEN-1:0]  val;
      off = elem_off(sew, idx);
      case (sew)
         2'd0:    val = ELEN'(vec[off +: 8]);
         2'd1:    val = ELEN'(vec[off +: 16]);
         default: val = ELEN'(vec[off +: 32]);
      endcase
      return val;
   endfunction

   function automatic logic [VLEN-1:0] elem_put(input logic [VLEN-1:0] vec, input logic [1:0] sew,
                                               input logic [VL_W-1:0] idx, input logic [ELEN-1:0] data);
      logic [OFF_W-1:0] off;
      logic [VLEN-1:0]  res;
      off = elem_off(sew, idx);
      res = vec;
      case (sew)
         2'd0:    res[off +: 8]  = data[7:0];
         2'd1:    res[off +: 16] = data[15:0];
         default: res[off +: 32] = data[31:0];
      endcase
      return res;
   endfunction

   state_t                     state_r;
   logic                       store_r;
   logic [1:0]                 sew_r;
   logic [XLEN-1:0]            stride_r;
   logic [XLEN-1:0]            addr_r;
   logic [VL_W-1:0]            n_r;
   logic [VL_W-1:0]            idx_r;
   logic [4:0]                 vd_r;
   logic [VLEN-1:0]            buf_r;
   logic                       req_ready_r;
   logic                       busy_r;
   logic [DATA_ADDR_WIDTH-1:0] mem_addr_r;
   logic                       mem_re_r;
   logic                       mem_we_r;
   logic [1:0]                 mem_size_r;
   logic [ELEN-1:0]            mem_wdata_r;
   logic                       vrf_we_r;
   logic [4:0]                 vrf_waddr_r;
   logic [VLEN-1:0]            vrf_wdata_r;
   logic                       done_r;
   logic                       err_r;
`ifdef VLSU_MASK_EN
   logic                       vm_r;
   logic [MAX_EL-1:0]          mask_r;
`endif

   logic [VL_W-1:0]            max_el_s;
   logic [VL_W-1:0]            n_eff_s;
   logic [VL_W-1:0]            idx_next_s;
   logic                       last_s;
   logic                       act_first_s;
   logic                       act_next_s;
   logic [VLEN-1:0]            buf_next_s;

   // Element count clamped to what fits in one vector register; reserved SEW gives zero.
   always_comb begin
      case (bus.req_sew)
         2'd0:    max_el_s = VL_W'(VLEN / 8);
         2'd1:    max_el_s = VL_W'(VLEN / 16);
         2'd2:    max_el_s = VL_W'(VLEN / 32);
         default: max_el_s = VL_ZERO;
      endcase
      if (bus.req_vl < max_el_s) begin
         n_eff_s = bus.req_vl;
      end else begin
         n_eff_s = max_el_s;
      end
   end

   assign idx_next_s = idx_r + VL_ONE;
   assign last_s     = (idx_r == (n_r - VL_ONE));

`ifdef VLSU_MASK_EN
   assign act_first_s = bus.req_vm | bus.req_mask[0];
   assign act_next_s  = vm_r | mask_r[idx_next_s[IDX_W-1:0]];
`else
   assign act_first_s = 1'b1;
   assign act_next_s  = 1'b1;
`endif

   // Merge the current load element; inactive or store cycles leave the buffer as is.
   always_comb begin
      if (mem_re_r) begin
         buf_next_s = elem_put(buf_r, sew_r, idx_r, bus.mem_rdata);
      end else begin
         buf_next_s = buf_r;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         store_r     <= 1'b0;
         sew_r       <= 2'd0;
         stride_r    <= '0;
         addr_r      <= '0;
         n_r         <= VL_ZERO;
         idx_r       <= VL_ZERO;
         vd_r        <= 5'd0;
         buf_r       <= '0;
         req_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         mem_addr_r  <= '0;
         mem_re_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_size_r  <= 2'd0;
         mem_wdata_r <= '0;
         vrf_we_r    <= 1'b0;
         vrf_waddr_r <= 5'd0;
         vrf_wdata_r <= '0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
`ifdef VLSU_MASK_EN
         vm_r        <= 1'b0;
         mask_r      <= '0;
`endif
      end else begin
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         vrf_we_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.req_valid && req_ready_r) begin
                  store_r     <= bus.req_store;
                  sew_r       <= bus.req_sew;
                  stride_r    <= bus.req_stride;
                  addr_r      <= bus.req_base + bus.req_stride;
                  n_r         <= n_eff_s;
                  idx_r       <= VL_ZERO;
                  vd_r        <= bus.req_vd;
                  buf_r       <= bus.req_data;
                  mem_size_r  <= bus.req_sew;
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  err_r       <= (bus.req_sew == 2'd3);
`ifdef VLSU_MASK_EN
                  vm_r        <= bus.req_vm;
                  mask_r      <= bus.req_mask;
`endif
                  if (n_eff_s == VL_ZERO) begin
                     state_r <= WB;
                     done_r  <= 1'b1;
                  end else begin
                     // Element 0 is presented in the very next cycle.
                     state_r     <= ACCESS;
                     mem_addr_r  <= bus.req_base[DATA_ADDR_WIDTH-1:0];
                     mem_re_r    <= ~bus.req_store & act_first_s;
                     mem_we_r    <= bus.req_store & act_first_s;
                     mem_wdata_r <= elem_get(bus.req_data, bus.req_sew, VL_ZERO);
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               buf_r <= buf_next_s;
               if (last_s) begin
                  state_r     <= WB;
                  mem_re_r    <= 1'b0;
                  mem_we_r    <= 1'b0;
                  done_r      <= 1'b1;
                  vrf_we_r    <= ~store_r;
                  vrf_waddr_r <= vd_r;
                  vrf_wdata_r <= buf_next_s;
               end else begin
                  // addr_r already holds the address of the next element.
                  idx_r       <= idx_next_s;
                  mem_addr_r  <= addr_r[DATA_ADDR_WIDTH-1:0];
                  addr_r      <= addr_r + stride_r;
                  mem_re_r    <= ~store_r & act_next_s;
                  mem_we_r    <= store_r & act_next_s;
                  mem_wdata_r <= elem_get(buf_r, sew_r, idx_next_s);
               end
            end
            WB: begin
               state_r     <= IDLE;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
               mem_re_r    <= 1'b0;
               mem_we_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_r;
   assign bus.busy      = busy_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_re    = mem_re_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_size  = mem_size_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.vrf_we    = vrf_we_r;
   assign bus.vrf_waddr = vrf_waddr_r;
   assign bus.vrf_wdata = vrf_wdata_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
endmodule

// File: tb/tb_vlsu_sequencer.sv
// Self-checking bench for vlsu_sequencer: byte-array DMEM, reference model computing addresses as
// base + i*stride and element values by plain shifting, directed plus randomized operations.
module tb_vlsu_sequencer;
   logic clk = 1'b0;
   logic rst;
   logic mem_init;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   vlsu_sequencer_if bus ();
   vlsu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] mem     [0:1023];
   logic [7:0] ref_mem [0:1023];

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 73 + 29) ^ (i >> 3));
   endfunction

   // DMEM model: little-endian, byte addresses wrap at 1 KiB.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata[7:0];
         if (bus.mem_size != 2'd0) mem[bus.mem_addr + 10'd1] <= bus.mem_wdata[15:8];
         if (bus.mem_size == 2'd2) begin
            mem[bus.mem_addr + 10'd2] <= bus.mem_wdata[23:16];
            mem[bus.mem_addr + 10'd3] <= bus.mem_wdata[31:24];
         end
      end
   end

   assign bus.mem_rdata = {mem[bus.mem_addr + 10'd3], mem[bus.mem_addr + 10'd2],
                           mem[bus.mem_addr + 10'd1], mem[bus.mem_addr]};

   function automatic logic [31:0] ref_read(input logic [9:0] a, input int nb);
      logic [31:0] v;
      v = 32'd0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[10'(a + 10'(k))];
      return v;
   endfunction

   task automatic drive_req(input bit st, input logic [31:0] base, input logic [31:0] stride,
                            input logic [1:0] sew, input logic [4:0] vl, input logic [4:0] vd,
                            input logic [127:0] data, input bit vm, input logic [15:0] mask);
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_base   = base;
      bus.req_stride = stride;
      bus.req_sew    = sew;
      bus.req_vl     = vl;
      bus.req_vd     = vd;
      bus.req_data   = data;
`ifdef VLSU_MASK_EN
      bus.req_vm     = vm;
      bus.req_mask   = mask;
`else
      if (vm && (mask == 16'hFFFF)) bus.req_vd = vd;
`endif
   endtask

   task automatic scramble_req();
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'($urandom);
      bus.req_base   = $urandom;
      bus.req_stride = $urandom;
      bus.req_sew    = 2'($urandom);
      bus.req_vl     = 5'($urandom);
      bus.req_vd     = 5'($urandom);
      bus.req_data   = {$urandom, $urandom, $urandom, $urandom};
`ifdef VLSU_MASK_EN
      bus.req_vm     = 1'($urandom);
      bus.req_mask   = 16'($urandom);
`endif
   endtask

   // One complete operation checked cycle by cycle against the reference model.
   task automatic test_op(input string name, input bit st, input logic [31:0] base,
                          input logic [31:0] stride, input logic [1:0] sew, input logic [4:0] vl,
                          input logic [4:0] vd, input logic [127:0] data, input bit vm,
                          input logic [15:0] mask, output logic [127:0] obs_res);
      int n, ew, lim;
      bit eff_vm, e_act;
      bit act [16];
      logic [9:0]   exp_addr [16];
      logic [31:0]  exp_wd   [16];
      logic [127:0] exp_res, fld, tmp;
      logic [31:0]  a32;
      logic [6:0]   exp_ctrl, got_ctrl;
      int bad;
      eff_vm = vm;
`ifndef VLSU_MASK_EN
      eff_vm = 1'b1;
`endif
      lim = (sew == 2'd3) ? 0 : (16 >> sew);
      n   = (int'(vl) < lim) ? int'(vl) : lim;
      ew  = 8 << sew;
      exp_res = data;
      for (int i = 0; i < n; i++) begin
         a32         = base + 32'(i) * stride;
         exp_addr[i] = a32[9:0];
         act[i]      = eff_vm || mask[i];
         fld         = ((128'd1 << ew) - 128'd1);
         tmp         = (data >> (i * ew)) & fld;
         exp_wd[i]   = tmp[31:0];
         if (act[i]) begin
            if (st) begin
               for (int k = 0; k < ew / 8; k++) ref_mem[10'(a32 + 32'(k))] = exp_wd[i][8*k +: 8];
            end else begin
               exp_res = (exp_res & ~(fld << (i * ew))) |
                         (128'(ref_read(a32[9:0], ew / 8)) << (i * ew));
            end
         end
      end

      tests_run++;
      if (bus.req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s ready_before_accept: got %b expected 1", name, bus.req_ready);
      end
      drive_req(st, base, stride, sew, vl, vd, data, vm, mask);
      @(posedge clk); #1;
      scramble_req();
      obs_res = '0;
      for (int cyc = 1; cyc <= n + 2; cyc++) begin
         e_act    = (cyc <= n) ? act[cyc-1] : 1'b0;
         exp_ctrl = {e_act && !st, e_act && st, (cyc == 1) && (sew == 2'd3), cyc == n + 1,
                     (cyc == n + 1) && !st && (n > 0), cyc <= n + 1, cyc == n + 2};
         got_ctrl = {bus.mem_re, bus.mem_we, bus.err, bus.done, bus.vrf_we, bus.busy, bus.req_ready};
         tests_run++;
         if (got_ctrl !== exp_ctrl) begin
            tests_failed++;
            $display("FAIL %s ctrl cyc%0d: got re,we,err,done,vrf_we,busy,ready=%b expected %b",
                     name, cyc, got_ctrl, exp_ctrl);
         end
         if (e_act) begin
            tests_run++;
            if ({bus.mem_addr, bus.mem_size} !== {exp_addr[cyc-1], sew}) begin
               tests_failed++;
               $display("FAIL %s addr cyc%0d: got addr=%h size=%0d expected addr=%h size=%0d",
                        name, cyc, bus.mem_addr, bus.mem_size, exp_addr[cyc-1], sew);
            end
            if (st) begin
               tests_run++;
               if (bus.mem_wdata !== exp_wd[cyc-1]) begin
                  tests_failed++;
                  $display("FAIL %s wdata cyc%0d: got %h expected %h", name, cyc, bus.mem_wdata,
                           exp_wd[cyc-1]);
               end
            end
         end
         if (exp_ctrl[2]) begin
            obs_res = bus.vrf_wdata;
            tests_run++;
            if ({bus.vrf_waddr, bus.vrf_wdata} !== {vd, exp_res}) begin
               tests_failed++;
               $display("FAIL %s vrf: got vd=%0d data=%h expected vd=%0d data=%h", name,
                        bus.vrf_waddr, bus.vrf_wdata, vd, exp_res);
            end
         end
         if (cyc < n + 2) begin
            @(posedge clk); #1;
         end
      end
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL %s dmem: got %0d differing bytes expected 0", name, bad);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      mem_init = 1'b1;
      scramble_req();
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.req_ready, bus.busy, bus.mem_re, bus.mem_we, bus.vrf_we, bus.done, bus.err} !== 7'b1000000 ||
          bus.mem_addr !== 10'd0 || bus.vrf_wdata !== 128'd0 || bus.mem_wdata !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_state: got ready,busy,re,we,vrf_we,done,err=%b expected 1000000",
                  {bus.req_ready, bus.busy, bus.mem_re, bus.mem_we, bus.vrf_we, bus.done, bus.err});
      end
      rst      = 1'b0;
      mem_init = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if ({bus.req_ready, bus.busy} !== 2'b10) begin
         tests_failed++;
         $display("FAIL reset_release: got ready,busy=%b expected 10", {bus.req_ready, bus.busy});
      end
   endtask

   task automatic test_unit_stride_load();
      logic [127:0] res;
      test_op("seed_words", 1'b1, 32'h100, 32'd4, 2'd2, 5'd4, 5'd0,
              128'h44444444_33333333_22222222_11111111, 1'b1, 16'hFFFF, res);
      test_op("unit_load", 1'b0, 32'h100, 32'd4, 2'd2, 5'd4, 5'd7,
              {$urandom, $urandom, $urandom, $urandom}, 1'b1, 16'hFFFF, res);
      tests_run++;
      if (res !== 128'h44444444_33333333_22222222_11111111) begin
         tests_failed++;
         $display("FAIL unit_load_value: got %h expected 44444444333333332222222211111111", res);
      end
   endtask

   task automatic test_store_wrap();
      logic [127:0] d, res;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[23:0] = 24'hCCBBAA;
      test_op("store_wrap", 1'b1, 32'h3FE, 32'd1, 2'd0, 5'd3, 5'd2, d, 1'b1, 16'hFFFF, res);
      tests_run++;
      if ({mem[10'h3FE], mem[10'h3FF], mem[10'h000]} !== 24'hAABBCC) begin
         tests_failed++;
         $display("FAIL store_wrap_bytes: got %h %h %h expected aa bb cc", mem[10'h3FE],
                  mem[10'h3FF], mem[10'h000]);
      end
   endtask

   task automatic test_negative_stride();
      logic [127:0] res;
      test_op("neg_stride", 1'b0, 32'h20, 32'hFFFFFFFE, 2'd1, 5'd2, 5'd31, {128{1'b1}}, 1'b1,
              16'hFFFF, res);
      tests_run++;
      if (res[127:32] !== {96{1'b1}}) begin
         tests_failed++;
         $display("FAIL neg_stride_tail: got %h expected all ones", res[127:32]);
      end
   endtask

   task automatic test_zero_and_reserved();
      logic [127:0] res;
      test_op("vl_zero", 1'b0, 32'h40, 32'd4, 2'd2, 5'd0, 5'd1, 128'd5, 1'b1, 16'hFFFF, res);
      test_op("sew3_load", 1'b0, 32'h40, 32'd4, 2'd3, 5'd4, 5'd1, 128'd6, 1'b1, 16'hFFFF, res);
      test_op("sew3_store", 1'b1, 32'h40, 32'd4, 2'd3, 5'd4, 5'd1, 128'd7, 1'b1, 16'hFFFF, res);
   endtask

   task automatic test_clamp();
      logic [127:0] res;
      test_op("clamp_w", 1'b0, 32'h200, 32'd8, 2'd2, 5'd20, 5'd3, 128'd0, 1'b1, 16'hFFFF, res);
      test_op("clamp_b", 1'b1, 32'h280, 32'd1, 2'd0, 5'd31, 5'd3,
              {$urandom, $urandom, $urandom, $urandom}, 1'b1, 16'hFFFF, res);
   endtask

   task automatic test_reset_mid_op();
      drive_req(1'b0, 32'h300, 32'd2, 2'd1, 5'd8, 5'd9, 128'd0, 1'b1, 16'hFFFF);
      @(posedge clk); #1;
      scramble_req();
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({bus.req_ready, bus.busy, bus.mem_re, bus.mem_we, bus.vrf_we, bus.done} !== 6'b100000) begin
         tests_failed++;
         $display("FAIL midop_reset: got ready,busy,re,we,vrf_we,done=%b expected 100000",
                  {bus.req_ready, bus.busy, bus.mem_re, bus.mem_we, bus.vrf_we, bus.done});
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         tests_run++;
         if ({bus.req_ready, bus.busy, bus.mem_re, bus.mem_we, bus.vrf_we, bus.done} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL after_reset c%0d: got ready,busy,re,we,vrf_we,done=%b expected 100000", c,
                     {bus.req_ready, bus.busy, bus.mem_re, bus.mem_we, bus.vrf_we, bus.done});
         end
      end
   endtask

   // Load of 2 words, then a held store request that must be taken the cycle after WB.
   task automatic test_back_to_back();
      logic [31:0] bb;
      logic [127:0] bd;
      logic [4:0] exp_c, got_c;
      logic [9:0] exp_a;
      bb = $urandom;
      bd = {$urandom, $urandom, $urandom, $urandom};
      drive_req(1'b0, 32'h100, 32'd4, 2'd2, 5'd2, 5'd4, 128'd0, 1'b1, 16'hFFFF);
      @(posedge clk); #1;
      drive_req(1'b1, bb, 32'd1, 2'd0, 5'd3, 5'd5, bd, 1'b1, 16'hFFFF);
      for (int k = 0; k < 3; k++) ref_mem[10'(bb + 32'(k))] = bd[8*k +: 8];
      for (int cyc = 1; cyc <= 9; cyc++) begin
         exp_c = {cyc <= 2, cyc >= 5 && cyc <= 7, cyc == 3 || cyc == 8, cyc == 3,
                  cyc == 4 || cyc == 9};
         got_c = {bus.mem_re, bus.mem_we, bus.done, bus.vrf_we, bus.req_ready};
         tests_run++;
         if (got_c !== exp_c) begin
            tests_failed++;
            $display("FAIL b2b ctrl cyc%0d: got re,we,done,vrf_we,ready=%b expected %b", cyc,
                     got_c, exp_c);
         end
         if (cyc >= 5 && cyc <= 7) begin
            exp_a = 10'(bb + 32'(cyc - 5));
            tests_run++;
            if ({bus.mem_addr, bus.mem_wdata} !== {exp_a, 24'd0, bd[8*(cyc-5) +: 8]}) begin
               tests_failed++;
               $display("FAIL b2b store cyc%0d: got addr=%h data=%h expected addr=%h data=%h", cyc,
                        bus.mem_addr, bus.mem_wdata, exp_a, bd[8*(cyc-5) +: 8]);
            end
         end
         if (cyc == 5) scramble_req();
         @(posedge clk); #1;
      end
   endtask

`ifdef VLSU_MASK_EN
   task automatic test_mask();
      logic [127:0] d, res;
      d = {$urandom, $urandom, $urandom, $urandom};
      test_op("mask_load", 1'b0, 32'h100, 32'd4, 2'd2, 5'd4, 5'd11, d, 1'b0, 16'h0005, res);
      tests_run++;
      if ({res[127:96], res[63:32]} !== {d[127:96], d[63:32]}) begin
         tests_failed++;
         $display("FAIL mask_keep: got %h expected %h", {res[127:96], res[63:32]},
                  {d[127:96], d[63:32]});
      end
      test_op("mask_store", 1'b1, 32'h180, 32'd2, 2'd1, 5'd8, 5'd0, d, 1'b0, 16'h00B6, res);
   endtask
`endif

   task automatic test_random();
      logic [127:0] res;
      logic [31:0] stride;
      logic [1:0] sew;
      for (int t = 0; t < 40; t++) begin
         sew = (t % 8 == 7) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0) stride = $urandom;
         else stride = 32'($urandom_range(0, 16)) - 32'd8;
         test_op("random", 1'($urandom), $urandom, stride, sew, 5'($urandom), 5'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 16'($urandom), res);
      end
   endtask

   initial begin
      test_reset();
      test_unit_stride_load();
      test_store_wrap();
      test_negative_stride();
      test_zero_and_reserved();
      test_clamp();
      test_reset_mid_op();
      test_unit_stride_load();
      test_back_to_back();
`ifdef VLSU_MASK_EN
      test_mask();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/vlsu_sequencer.md
Name: vlsu_sequencer

Overview:
- Sequences one vector unit-stride or strided load/store into per-element accesses on the shared scalar DMEM port, one element per cycle.
- Assembles load results into a VLEN-wide word and issues a single VRF write.
- Sits between vector decode/issue and the DMEM port of the scalar datapath; it owns that port while busy.

Parameters:
- XLEN, 32, scalar address/stride width
- DATA_ADDR_WIDTH, 10, DMEM byte-address width; addresses wrap modulo 2**DATA_ADDR_WIDTH
- VLEN, 128, vector register width in bits
- ELEN, 32, max element width; DMEM data port width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_store  in  1  1=store, 0=load
- req_base  in  XLEN  base byte address
- req_stride  in  XLEN  byte stride, two's complement
- req_sew  in  2  0=8b, 1=16b, 2=32b, 3=reserved
- req_vl  in  $clog2(VLEN/8)+1  element count
- req_vd  in  5  destination/source vector register index
- req_data  in  VLEN  old vd value for loads (tail/inactive fill); vs3 value for stores
- mem_addr  out  DATA_ADDR_WIDTH  DMEM byte address
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_size  out  2  0=byte, 1=half, 2=word (equals SEW)
- mem_wdata  out  ELEN  store element, zero-extended
- mem_rdata  in  ELEN  combinational read data, valid in the same cycle as mem_re
- vrf_we  out  1  one-cycle VRF write pulse
- vrf_waddr  out  5  VRF write index
- vrf_wdata  out  VLEN  assembled load result
- busy  out  1  high outside IDLE; scalar side must not use DMEM while high
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on reserved SEW

Behaviour:
- Reset, asynchronous: FSM=IDLE; all outputs 0 except req_ready=1; internal registers cleared.
- A reset mid-operation abandons the operation:
  - no further memory strobes;
  - no vrf_we or done;
  - memory writes already made stay in DMEM.
- FSM states: IDLE, ACCESS, WB.
- IDLE:
  - Accept on req_valid && req_ready; latch all req_* fields in cycle 0.
  - Effective count n = min(req_vl, VLEN/(8<<sew)).
  - sew=3 → err pulse in cycle 1, then treat as n=0.
  - n=0 → go to WB.
  - Otherwise go to ACCESS with idx=0, addr=base.
- ACCESS, element idx in cycle idx+1:
  - mem_addr = addr[DATA_ADDR_WIDTH-1:0].
  - Load: mem_re=1; capture mem_rdata[SEW-1:0] into element idx of the result buffer.
  - Store: mem_we=1; mem_wdata = element idx of req_data.
  - After each element: addr += stride (XLEN wrap), idx += 1.
  - After element n-1, go to WB.
- Result buffer is preloaded with req_data, so tail elements (idx ≥ n) stay undisturbed.
- WB, one cycle (cycle n+1):
  - done=1.
  - Loads with n>0 also assert vrf_we=1, vrf_waddr=latched vd, vrf_wdata=buffer.
  - Stores and n=0 assert no vrf_we.
  - Next state IDLE.
- Latency: accept→done is n+1 cycles. req_ready returns the cycle after done.
- Back-to-back: a new request may be accepted in the cycle after WB.
- mem_re, mem_we, vrf_we, done and err are 0 in every cycle not listed above. mem_re and mem_we are never both high.
- req_valid while busy is ignored; the requester holds it.

Optional Feature:
- Macro VLSU_MASK_EN.
- Defined:
  - Adds ports req_vm (1, in) and req_mask (VLEN/8, in), latched at accept.
  - When req_vm=0 and req_mask[idx]=0, element idx still takes its cycle, but mem_re and mem_we stay 0. The load element keeps its old value from req_data.
  - req_vm=1 means all elements are active.
- Not defined: the ports are absent and all elements are active.

Test Plan:
- Load, sew=2, vl=4, base=0x100, stride=4, DMEM words 0x11111111..0x44444444 → mem_addr 0x100,0x104,0x108,0x10C in cycles 1–4; cycle 5: vrf_we=1, vrf_wdata=0x44444444_33333333_22222222_11111111, done=1.
- Store, sew=0, vl=3, base=0x3FE, stride=1, req_data[23:0]=0xCCBBAA → bytes 0xAA@0x3FE, 0xBB@0x3FF, 0xCC@0x000 (wrap); no vrf_we; done in cycle 4.
- Load, sew=1, vl=2, stride=-2 (0xFFFFFFFE), base=0x20, req_data all 0xFFFF → addrs 0x20, 0x1E; upper 6 halfwords of vrf_wdata remain 0xFFFF.
- vl=0 → no mem strobes, no vrf_we, done in cycle 1. sew=3, vl=4 → err in cycle 1, no strobes, done in cycle 1.
- vl=20 with sew=2 → clamped to 4 accesses. rst asserted in cycle 2 of an 8-element load → outputs 0 immediately, req_ready=1 after release, no vrf_we.
- VLSU_MASK_EN, load sew=2, vl=4, vm=0, mask=0b0101 → mem_re only in cycles 1 and 3; elements 1 and 3 equal req_data.
